// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: depth/padding helpers and the valid/oor sideband carried down the mux pipeline.
package mux_pipe_pkg;
  typedef struct packed {
    logic valid;
    logic oor;
  } side_t;
  function automatic int stages_f(int n);
    return ($clog2(n) + 1) / 2;
  endfunction
  function automatic int padded_f(int n);
    return 1 << $clog2(n);
  endfunction
endpackage

// File: rtl/mux_pipe_nxm_if.sv
// mux_pipe_nxm_if: request/result bundle of the pipelined selector; err_o exists only with MUX_PIPE_RANGE_CHECK_EN.
interface mux_pipe_nxm_if #(
  parameter int NUM_INPUTS = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs_i;
  logic [SEL_WIDTH-1:0] selects_i;
  logic valid_i;
  logic ready_o;
  logic [DATA_WIDTH-1:0] outputs_o;
  logic valid_o;
  logic ready_i;
`ifdef MUX_PIPE_RANGE_CHECK_EN
  logic err_o;
  modport master (output inputs_i, selects_i, valid_i, ready_i, input ready_o, outputs_o, valid_o, err_o);
  modport slave (input inputs_i, selects_i, valid_i, ready_i, output ready_o, outputs_o, valid_o, err_o);
`else
  modport master (output inputs_i, selects_i, valid_i, ready_i, input ready_o, outputs_o, valid_o);
  modport slave (input inputs_i, selects_i, valid_i, ready_i, output ready_o, outputs_o, valid_o);
`endif
endinterface

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: one registered radix-2/4 reduction level with enable and sideband pass-through.
module mux_pipe_stage
  import mux_pipe_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int RADIX = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_W = 2,
  localparam int N_OUT = N_IN / RADIX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic [N_IN-1:0][DATA_WIDTH-1:0] cand_i,
  input  logic [SEL_W-1:0] sel_i,
  input  side_t side_i,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0] cand_o,
  output logic [SEL_W-1:0] sel_o,
  output side_t side_o
);
  localparam int LB = (RADIX == 4) ? 2 : 1;
  localparam int IW = $clog2(N_IN);
  logic [N_OUT-1:0][DATA_WIDTH-1:0] cand_d, cand_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  side_t side_d, side_q;
  always_comb begin
    for (int g = 0; g < N_OUT; g++) cand_d[g] = cand_i[IW'(g * RADIX) + IW'(sel_i[LB-1:0])];
    sel_d = sel_i >> LB;
    side_d = side_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q <= '0;
      sel_q <= '0;
      side_q <= '0;
    end else if (en_i) begin
      cand_q <= cand_d;
      sel_q <= sel_d;
      side_q <= side_d;
    end
  end
  assign cand_o = cand_q;
  assign sel_o = sel_q;
  assign side_o = side_q;
endmodule

// File: rtl/mux_pipe_nxm.sv
// mux_pipe_nxm: pipelined N-input selector, one radix-4 stage per level (radix-2 last for odd select width).
// Define MUX_PIPE_RANGE_CHECK_EN to flag out-of-range selects on err_o.
module mux_pipe_nxm
  import mux_pipe_pkg::*;
#(
  parameter int NUM_INPUTS = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic clk_i,
  input logic rst_ni,
  mux_pipe_nxm_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);
  localparam int STAGES = stages_f(NUM_INPUTS);
  localparam int PADDED = padded_f(NUM_INPUTS);
  logic en;
  logic [PADDED-1:0][DATA_WIDTH-1:0] pad;
  side_t side0, side_last;
  logic unused_ok;
  always_comb begin
    en = !bus.valid_o || bus.ready_i;
    pad = '0;
    pad[NUM_INPUTS-1:0] = bus.inputs_i;
    side0.valid = bus.valid_i;
`ifdef MUX_PIPE_RANGE_CHECK_EN
    side0.oor = (NUM_INPUTS != PADDED) && (int'(bus.selects_i) >= NUM_INPUTS);
`else
    side0.oor = 1'b0;
`endif
  end
  assign bus.ready_o = en;
  // Each level consumes two select bits; zero padding makes out-of-range picks yield 0.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int NI = PADDED >> (2 * k);
    localparam int R = (NI == 2) ? 2 : 4;
    logic [NI-1:0][DATA_WIDTH-1:0] cand_in;
    logic [NI/R-1:0][DATA_WIDTH-1:0] cand_out;
    logic [SEL_WIDTH-1:0] sel_in, sel_out;
    side_t side_in, side_out;
    if (k == 0) begin : g_head
      assign cand_in = pad;
      assign sel_in = bus.selects_i;
      assign side_in = side0;
    end else begin : g_link
      assign cand_in = g_st[k-1].cand_out;
      assign sel_in = g_st[k-1].sel_out;
      assign side_in = g_st[k-1].side_out;
    end
    mux_pipe_stage #(
      .N_IN(NI),
      .RADIX(R),
      .DATA_WIDTH(DATA_WIDTH),
      .SEL_W(SEL_WIDTH)
    ) u_stage (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .en_i(en),
      .cand_i(cand_in),
      .sel_i(sel_in),
      .side_i(side_in),
      .cand_o(cand_out),
      .sel_o(sel_out),
      .side_o(side_out)
    );
  end
  assign bus.outputs_o = g_st[STAGES-1].cand_out[0];
  assign side_last = g_st[STAGES-1].side_out;
  assign bus.valid_o = side_last.valid;
`ifdef MUX_PIPE_RANGE_CHECK_EN
  assign bus.err_o = side_last.oor && side_last.valid;
`endif
  assign unused_ok = ^{g_st[STAGES-1].sel_out, side_last.oor};
endmodule

// File: tb/tb_mux_pipe_nxm.sv
// tb_mux_pipe_nxm: table-driven stream plus directed stall, padding, small-config and reset sequences.
module tb_mux_pipe_nxm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mux_pipe_nxm_if #(.NUM_INPUTS(32), .DATA_WIDTH(64)) b32 ();
  mux_pipe_nxm_if #(.NUM_INPUTS(20), .DATA_WIDTH(64)) b20 ();
  mux_pipe_nxm_if #(.NUM_INPUTS(2), .DATA_WIDTH(64)) b2 ();
  mux_pipe_nxm #(.NUM_INPUTS(32), .DATA_WIDTH(64)) u32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
  mux_pipe_nxm #(.NUM_INPUTS(20), .DATA_WIDTH(64)) u20 (.clk_i(clk), .rst_ni(rst_n), .bus(b20));
  mux_pipe_nxm #(.NUM_INPUTS(2), .DATA_WIDTH(64)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(b2));
  typedef struct {
    logic vi;
    logic [4:0] sel;
    logic ri;
    logic vo;
    logic [63:0] out;
    logic rdy;
  } vec_t;
  localparam int NV = 46;
  vec_t tbl [NV];
  localparam logic [63:0] V0 = 64'hAAAA_0000_1111_AAAA;
  localparam logic [63:0] V1 = 64'h5555_2222_0000_5555;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 32; k++) b32.inputs_i[k] = 64'(k) * 64'h0101;
    for (int k = 0; k < 20; k++) b20.inputs_i[k] = 64'(k) * 64'h0101;
    b2.inputs_i[0] = V0;
    b2.inputs_i[1] = V1;
    b32.valid_i = 1'b0; b32.selects_i = '0; b32.ready_i = 1'b1;
    b20.valid_i = 1'b0; b20.selects_i = '0; b20.ready_i = 1'b1;
    b2.valid_i = 1'b0; b2.selects_i = '0; b2.ready_i = 1'b1;
    for (int t = 0; t < NV; t++) begin
      tbl[t].ri = 1'b1;
      if (t < 34) begin
        tbl[t].vi = (t < 32);
        tbl[t].sel = 5'(t);
      end else begin
        tbl[t].vi = ((t - 34) % 2 == 0) && (t - 34 < 8);
        tbl[t].sel = 5'(10 + t - 34);
      end
    end
    for (int t = 0; t < NV; t++) begin
      tbl[t].vo = (t >= 2) ? tbl[t-2].vi : 1'b0;
      tbl[t].out = (t >= 2) ? 64'(tbl[t-2].sel) * 64'h0101 : 64'h0;
      tbl[t].rdy = 1'b1;
    end
    step();
    step();
    chk("reset valid_o", 64'(b32.valid_o), 64'd0);
    chk("reset outputs_o", b32.outputs_o, 64'd0);
    chk("reset ready_o", 64'(b32.ready_o), 64'd1);
    chk("reset n20 valid_o", 64'(b20.valid_o), 64'd0);
    chk("reset n2 outputs_o", b2.outputs_o, 64'd0);
`ifdef MUX_PIPE_RANGE_CHECK_EN
    chk("reset err_o", 64'(b20.err_o), 64'd0);
`endif
    rst_n = 1'b1;
    for (int t = 0; t < NV; t++) begin
      b32.valid_i = tbl[t].vi;
      b32.selects_i = tbl[t].sel;
      b32.ready_i = tbl[t].ri;
      step();
      chk($sformatf("row%0d valid_o", t), 64'(b32.valid_o), 64'(tbl[t].vo));
      chk($sformatf("row%0d ready_o", t), 64'(b32.ready_o), 64'(tbl[t].rdy));
      if (tbl[t].vo) chk($sformatf("row%0d outputs_o", t), b32.outputs_o, tbl[t].out);
`ifdef MUX_PIPE_RANGE_CHECK_EN
      chk($sformatf("row%0d err_o", t), 64'(b32.err_o), 64'd0);
`endif
    end
    b32.valid_i = 1'b1;
    b32.selects_i = 5'd5; step();
    b32.selects_i = 5'd6; step();
    b32.selects_i = 5'd7; step();
    chk("bp first valid", 64'(b32.valid_o), 64'd1);
    chk("bp first data", b32.outputs_o, 64'h0505);
    b32.selects_i = 5'd8;
    b32.ready_i = 1'b0;
    #1;
    chk("bp ready_o low", 64'(b32.ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp stall valid", 64'(b32.valid_o), 64'd1);
      chk("bp stall data", b32.outputs_o, 64'h0505);
      chk("bp stall ready_o", 64'(b32.ready_o), 64'd0);
    end
    b32.ready_i = 1'b1;
    #1;
    chk("bp release ready_o", 64'(b32.ready_o), 64'd1);
    step();
    b32.valid_i = 1'b0;
    chk("bp out 6", b32.outputs_o, 64'h0606);
    step();
    chk("bp out 7", b32.outputs_o, 64'h0707);
    step();
    chk("bp out 8", b32.outputs_o, 64'h0808);
    chk("bp out 8 valid", 64'(b32.valid_o), 64'd1);
    step();
    chk("bp drained", 64'(b32.valid_o), 64'd0);
    b20.valid_i = 1'b1;
    b20.selects_i = 5'd19; step();
    b20.selects_i = 5'd25; step();
    b20.valid_i = 1'b0; step();
    chk("n20 sel19 valid", 64'(b20.valid_o), 64'd1);
    chk("n20 sel19 data", b20.outputs_o, 64'h1313);
`ifdef MUX_PIPE_RANGE_CHECK_EN
    chk("n20 sel19 err", 64'(b20.err_o), 64'd0);
`endif
    step();
    chk("n20 sel25 valid", 64'(b20.valid_o), 64'd1);
    chk("n20 sel25 data", b20.outputs_o, 64'd0);
`ifdef MUX_PIPE_RANGE_CHECK_EN
    chk("n20 sel25 err", 64'(b20.err_o), 64'd1);
`endif
    step();
    chk("n20 drained", 64'(b20.valid_o), 64'd0);
`ifdef MUX_PIPE_RANGE_CHECK_EN
    chk("n20 err idle", 64'(b20.err_o), 64'd0);
`endif
    b2.valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b2.selects_i = 1'(i % 2);
      step();
      chk("n2 valid", 64'(b2.valid_o), 64'd1);
      chk("n2 data", b2.outputs_o, (i % 2 == 1) ? V1 : V0);
    end
    b2.valid_i = 1'b0;
    step();
    chk("n2 drained", 64'(b2.valid_o), 64'd0);
    b32.ready_i = 1'b0;
    b32.valid_i = 1'b1;
    b32.selects_i = 5'd1; step();
    b32.selects_i = 5'd2; step();
    b32.selects_i = 5'd3; step();
    b32.valid_i = 1'b0;
    chk("rst full valid", 64'(b32.valid_o), 64'd1);
    chk("rst full data", b32.outputs_o, 64'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 64'(b32.valid_o), 64'd0);
    chk("rst async data", b32.outputs_o, 64'd0);
    chk("rst async ready_o", 64'(b32.ready_o), 64'd1);
    step();
    rst_n = 1'b1;
    b32.ready_i = 1'b1;
    b32.valid_i = 1'b1;
    b32.selects_i = 5'd9;
    step();
    b32.valid_i = 1'b0;
    chk("rst lat c1", 64'(b32.valid_o), 64'd0);
    step();
    chk("rst lat c2", 64'(b32.valid_o), 64'd0);
    step();
    chk("rst lat c3 valid", 64'(b32.valid_o), 64'd1);
    chk("rst lat c3 data", b32.outputs_o, 64'h0909);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
